booth_mult_seq: RTL and testbench
=================================

# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier with its control unit built in. It replaces the fixed 8-bit datapath and external CU with one block: WIDTH-bit operands, per-operation signed/unsigned mode, a Start/Busy/Done handshake and a registered full-width product. It sits as a multi-cycle arithmetic unit behind the team's ALU issue logic.

## Interface
- WIDTH, 8: operand width in bits; legal values are 2..32.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low; clears all state.
- Start  input  1  request pulse, sampled only while the block is not busy.
- Signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with Start.
- M  input  WIDTH  multiplicand; captured with Start.
- N  input  WIDTH  multiplier; captured with Start.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when Product is updated.
- Product  output  2*WIDTH  result register; holds its value until the next completion.

## Operation
- States:
  - IDLE: reset state.
  - RUN: one Booth iteration per cycle.
  - DONE: one cycle, then back to IDLE.
- Start is accepted in IDLE or DONE. It is ignored in RUN; there is no queueing.
- Capture on accept:
  - Mx = M extended to WIDTH+2 bits: sign-extended if Signed=1, zero-extended if Signed=0.
  - Q = N extended to WIDTH+1 bits, using the same rule.
  - A = 0 (WIDTH+2 bits).
  - Q_1 = 0.
  - count = 0.
  - state goes to RUN.
- RUN iteration, based on {Q[0], Q_1}:
  - 01: A = A + Mx.
  - 10: A = A - Mx.
  - 00 or 11: A unchanged.
  - Then arithmetic shift right of {A, Q, Q_1} by 1 bit, with A's MSB replicated.
  - count increments.
- RUN runs exactly WIDTH+1 iterations. Early termination is not used.
- On the final iteration:
  - Product is loaded with the low 2*WIDTH bits of the post-shift {A, Q}.
  - state goes to DONE.
- Width rule: A is WIDTH+2 bits, so the add/subtract never overflows, including M = most negative value in signed mode. Product is exact for all operand pairs in both modes.
- Unsigned mode is the same datapath with zero-extended operands. The extra iteration consumes the zero extension bit.
- Signed is latched at Start; changing it mid-operation has no effect.

## Timing
- Reset values:
  - Busy = 0, Done = 0, Product = 0.
  - State is IDLE; A, Q, Q_1 and count are 0.
- Reset asserted mid-operation aborts the operation immediately. Product returns to 0 and no Done is generated.
- Start accepted at clock edge E0:
  - Busy is high from after E0 until after edge E0+WIDTH+1, i.e. for WIDTH+1 cycles.
  - Product updates at edge E0+WIDTH+1.
  - Done is high for the one cycle after E0+WIDTH+1.
- Total latency is Start to Done = WIDTH+1 cycles. For WIDTH=8 this is 9 cycles.
- Back-to-back operation:
  - Start high during the DONE cycle is accepted at that edge.
  - Busy rises again with no idle cycle, and Done drops on schedule.
  - Throughput is one result per WIDTH+2 cycles.
- Start held high continuously restarts at every DONE edge.
- Inputs are sampled only at the accept edge.
- Outputs are driven from registers only. There is no combinational path from any input to any output.

## Test plan
All scenarios use WIDTH=8.
- Signed=1, M=-128 (0x80), N=-128 -> after 9 cycles Done pulses once and Product=0x4000. Repeat with N=127 -> Product=0xC080.
- Signed=0, M=0xFF, N=0xFF -> Product=0xFE01. Same operand bits with Signed=1 -> Product=0x0001.
- Signed=1, M=0x7F, N=0xFF (-1) -> Product=0xFF81. M=0, N=0x5A -> Product=0x0000. Busy is high for exactly 9 cycles in each case.
- Start pulsed again during RUN with different operands -> ignored: the original result is delivered and there is one Done per accepted Start.
- Start held high through DONE with new operands 3×5 (unsigned) -> second operation starts at the DONE edge and Product=0x000F 10 cycles after the first Done.
- Reset pulled low at iteration 4 of 0x12×0x34 -> Busy=0, Product=0 immediately and no Done. After release, 0x12×0x34 unsigned gives Product=0x03A8.

Source files
------------

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier with built-in control.
// Takes WIDTH-bit operands in signed or unsigned mode and produces a
// registered 2*WIDTH-bit product after WIDTH+1 iterations.
//
// Handshake: start is sampled on a rising edge only while busy is low
// (states IDLE or DONE); such an edge is the accept edge, where is_signed,
// m and n are captured. busy is high for exactly the WIDTH+1 cycles of
// iteration, then done pulses for one cycle while product holds the new
// result. Start during RUN is dropped, never queued. All outputs are
// registers.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   n,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         state_dbg
);

  // Count only has to reach WIDTH (index of the last iteration).
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH+1:0] a;
  logic [WIDTH+1:0] mx;
  logic [WIDTH:0]   q;
  logic             q_1;
  logic [CW-1:0]    count;

  logic [WIDTH+1:0] a_sum;
  logic [WIDTH+1:0] a_nx;
  logic [WIDTH:0]   q_nx;
  logic             accept;
  logic             last_iter;

  assign accept    = start && (state != RUN);
  assign last_iter = (count == CW'(WIDTH));
  assign state_dbg = state;

  // Booth add/subtract followed by a one-bit arithmetic right shift of {A,Q,Q_1}.
  // A carries two guard bits, so A - Mx cannot overflow even for the most
  // negative signed multiplicand.
  always_comb begin
    a_sum = a;
    case ({q[0], q_1})
      2'b01:   a_sum = a + mx;
      2'b10:   a_sum = a - mx;
      default: a_sum = a;
    endcase
    a_nx = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
    q_nx = {a_sum[0], q[WIDTH:1]};
  end

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a       <= '0;
      mx      <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        RUN: begin
          a     <= a_nx;
          q     <= q_nx;
          q_1   <= q[0];
          count <= count + 1'b1;
          if (last_iter) begin
            // Exact product fits in the low 2*WIDTH bits of {A,Q}.
            product <= {a_nx[WIDTH-2:0], q_nx};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE lasts one cycle.
          done <= 1'b0;
          if (accept) begin
            mx    <= is_signed ? {{2{m[WIDTH-1]}}, m} : {2'b00, m};
            q     <= {is_signed & n[WIDTH-1], n};
            a     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Testbench for booth_mult_seq (WIDTH=8): directed vectors with hand-computed
// products, scoreboard queue checked by an independent monitor on done.
module tb_booth_mult_seq;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   m;
  logic [W-1:0]   n;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [1:0]     state_dbg;

  int checks    = 0;
  int errors    = 0;
  int done_cnt  = 0;
  int exp_dones = 0;

  logic [2*W-1:0] exp_q[$];

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .m         (m),
    .n         (n),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest expected product.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got product 0x%0h expected no done", product);
      end else begin
        check("product", product, exp_q.pop_front());
      end
    end
  end

  // Wait for done after an accept edge (called #1 after that edge);
  // checks latency and number of busy cycles.
  task automatic wait_done(input string name, input int exp_lat);
    int lat = 0;
    int bc  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, bc, exp_lat);
  endtask

  // Issue one operation, expect it to be accepted and complete normally.
  task automatic do_op(input string name, input logic sg, input logic [W-1:0] mm,
                       input logic [W-1:0] nn, input logic [2*W-1:0] exp);
    @(negedge clk);
    is_signed = sg; m = mm; n = nn; start = 1'b1;
    exp_q.push_back(exp);
    exp_dones++;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(name, W + 1);
    @(posedge clk); #1;
    check({name, "_done_pulse_width"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; m = '0; n = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    check("reset_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed vectors
    do_op("s_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000);
    do_op("s_m128_127",  1'b1, 8'h80, 8'h7F, 16'hC080);
    do_op("u_ff_ff",     1'b0, 8'hFF, 8'hFF, 16'hFE01);
    do_op("s_ff_ff",     1'b1, 8'hFF, 8'hFF, 16'h0001);
    do_op("s_7f_m1",     1'b1, 8'h7F, 8'hFF, 16'hFF81);
    do_op("s_0_5a",      1'b1, 8'h00, 8'h5A, 16'h0000);
    do_op("u_80_80",     1'b0, 8'h80, 8'h80, 16'h4000);
    do_op("s_7f_7f",     1'b1, 8'h7F, 8'h7F, 16'h3F01);

    // Start during RUN is ignored
    @(negedge clk);
    is_signed = 1'b0; m = 8'd10; n = 8'd20; start = 1'b1;
    exp_q.push_back(16'h00C8);
    exp_dones++;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    is_signed = 1'b1; m = 8'hFF; n = 8'h7F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore_run", W + 1 - 4);
    repeat (15) @(posedge clk);
    #1;
    check("ignore_run_idle_busy", busy, 0);

    // Start held high: back-to-back restart at the DONE edge
    @(negedge clk);
    is_signed = 1'b0; m = 8'd10; n = 8'd11; start = 1'b1;
    exp_q.push_back(16'h006E);
    exp_q.push_back(16'h000F);
    exp_dones += 2;
    @(posedge clk); #1;
    m = 8'd3; n = 8'd5;
    wait_done("b2b_first", W + 1);
    @(posedge clk); #1;
    check("b2b_restart_busy", busy, 1);
    check("b2b_done_dropped", done, 0);
    wait_done("b2b_second", W + 1);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle_busy", busy, 0);

    // Reset mid-operation aborts without done
    @(negedge clk);
    is_signed = 1'b0; m = 8'h12; n = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done_product", product, 0);
    do_op("u_12_34", 1'b0, 8'h12, 8'h34, 16'h03A8);

    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_count", done_cnt, exp_dones);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
